// File: rtl/rf_port_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_port_sched_pkg : shared types and defaults for the RF port scheduler
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
package rf_port_sched_pkg;

   localparam int RF_ADDR_W = 3;
   localparam int RF_DATA_W = 8;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } sched_state_t;

   typedef struct packed {
      logic                 wr;
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } rf_op_t;

endpackage
`default_nettype wire

// File: rtl/rf_port_sched_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_port_sched_rr_pick : rotate-priority picker, first valid at or above ptr
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module rf_port_sched_rr_pick #(
   parameter int N_REQ = 2,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = PTR_W'((int'(ptr) + k) % N_REQ);
         if (!found && valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rf_port_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_port_sched : round-robin scheduler sharing one single-port RF among
//                 N_REQ requesters, with bounded lock and read-data routing
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module rf_port_sched
   import rf_port_sched_pkg::*;
#(
   parameter int N_REQ    = 2,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int DATA_W   = RF_DATA_W,
   parameter int LOCK_MAX = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ-1:0]         req_wr,
   input  logic [N_REQ*ADDR_W-1:0]  req_addr,
   input  logic [N_REQ*DATA_W-1:0]  req_wdata,
   input  logic [N_REQ-1:0]         req_lock,
   output logic [N_REQ-1:0]         rsp_valid,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     rf_wr,
   output logic                     rf_rd,
   output logic [ADDR_W-1:0]        rf_addr,
   output logic [DATA_W-1:0]        rf_din,
   input  logic [DATA_W-1:0]        rf_dout,
   input  logic                     rf_error,
   output logic                     err
);

   localparam int               PTR_W    = $clog2(N_REQ);
   localparam int               CNT_W    = $clog2(LOCK_MAX + 1);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(LOCK_MAX - 1);

   sched_state_t      state, state_nxt;
   logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt;
   logic [PTR_W-1:0]  owner, owner_nxt;
   logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
   logic [N_REQ-1:0]  pick;
   logic [N_REQ-1:0]  xfer;
   logic              xfer_any;
   logic [PTR_W-1:0]  xfer_idx;
   logic              lock_expire;
   logic              sel_wr;
   logic              sel_lock;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              p1_vld, p2_vld;
   logic [PTR_W-1:0]  p1_id, p2_id;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
      return (i == LAST_IDX) ? '0 : i + 1'b1;
   endfunction

   rf_port_sched_rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .grant (pick)
   );

   assign lock_expire = (state == LOCKED) && (lock_cnt == CNT_END);
   assign xfer        = req_valid & req_ready;
   assign xfer_any    = |xfer;

   // Ready is held low while in reset so nothing is accepted mid-reset.
   always_comb begin
      req_ready = '0;
      if (resetn) begin
         case (state)
            IDLE:    req_ready = pick;
            LOCKED:  if (!lock_expire) req_ready[owner] = req_valid[owner];
            default: req_ready = '0;
         endcase
      end
   end

   always_comb begin
      xfer_idx = '0;
      sel_wr   = 1'b0;
      sel_lock = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (xfer[i]) begin
            xfer_idx = PTR_W'(i);
            sel_wr   = req_wr[i];
            sel_lock = req_lock[i];
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_data = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      owner_nxt    = owner;
      lock_cnt_nxt = lock_cnt;
      case (state)
         IDLE: begin
            if (xfer_any) begin
               rr_ptr_nxt = wrap_inc(xfer_idx);
               if (sel_lock) begin
                  state_nxt    = LOCKED;
                  owner_nxt    = xfer_idx;
                  lock_cnt_nxt = '0;
               end
            end
         end
         LOCKED: begin
            lock_cnt_nxt = lock_cnt + 1'b1;
            if (lock_expire) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = wrap_inc(owner);
            end else if (xfer_any && !sel_lock) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         lock_cnt <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         owner    <= owner_nxt;
         lock_cnt <= lock_cnt_nxt;
      end
   end

   // Issue stage plus a two-deep requester-id pipe matching RF read latency.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rf_wr   <= 1'b0;
         rf_rd   <= 1'b0;
         rf_addr <= '0;
         rf_din  <= '0;
         p1_vld  <= 1'b0;
         p1_id   <= '0;
         p2_vld  <= 1'b0;
         p2_id   <= '0;
         err     <= 1'b0;
      end else begin
         rf_wr  <= xfer_any & sel_wr;
         rf_rd  <= xfer_any & ~sel_wr;
         if (xfer_any) begin
            rf_addr <= sel_addr;
            rf_din  <= sel_data;
         end
         p1_vld <= xfer_any & ~sel_wr;
         p1_id  <= xfer_idx;
         p2_vld <= p1_vld;
         p2_id  <= p1_id;
         if (rf_error) err <= 1'b1;
      end
   end

   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      if (p2_vld) begin
         rsp_valid[p2_id] = 1'b1;
         rsp_data         = rf_dout;
      end
   end

endmodule
`default_nettype wire
